// File: rtl/register_file_sb.sv
// register_file_sb: scoreboarded register file with two combinational read
// ports, one reservation port and one write-back port.
//   Each register holds data, a busy flag and the tag of the producer that
//   last reserved it. A write-back always updates data but releases busy
//   only when its tag matches the stored tag. When a reservation and a
//   write-back hit the same register in the same cycle, the reservation wins.
//   Indices >= NUM_REGS are ignored for updates and read back as zero.
// Optional feature (macro REGISTER_FILE_SB_BYPASS_EN):
//   A same-cycle write-back is forwarded to any read port whose index it
//   hits, including the post-write-back busy value. busy_vec_o always shows
//   registered state only.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rs1_idx_i / rs2_idx_i     read indices
//   rs1_data_o / rs2_data_o   read data
//   rs1_busy_o / rs2_busy_o   read busy status
//   rsv_valid_i/idx_i/tag_i   reservation request
//   wb_valid_i/idx_i/tag_i/data_i  write-back request
//   busy_vec_o                registered busy flag per register
module register_file_sb #(
  parameter int unsigned        LEN_REG      = 32,
  parameter int unsigned        NUM_REGS     = 16,
  parameter int unsigned        LEN_IDX      = 4,
  parameter int unsigned        LEN_TAG      = 3,
  parameter logic [LEN_REG-1:0] INITIAL_DATA = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_IDX-1:0]  rs1_idx_i,
  input  logic [LEN_IDX-1:0]  rs2_idx_i,
  output logic [LEN_REG-1:0]  rs1_data_o,
  output logic [LEN_REG-1:0]  rs2_data_o,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  input  logic                rsv_valid_i,
  input  logic [LEN_IDX-1:0]  rsv_idx_i,
  input  logic [LEN_TAG-1:0]  rsv_tag_i,
  input  logic                wb_valid_i,
  input  logic [LEN_IDX-1:0]  wb_idx_i,
  input  logic [LEN_TAG-1:0]  wb_tag_i,
  input  logic [LEN_REG-1:0]  wb_data_i,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [LEN_REG-1:0]  r_data [NUM_REGS];
  logic [LEN_TAG-1:0]  r_tag  [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [NUM_REGS-1:0] w_rsv_hit;
  logic [NUM_REGS-1:0] w_wb_hit;
  logic [NUM_REGS-1:0] w_tag_match;

  logic [LEN_REG-1:0]  w_rs1_data;
  logic [LEN_REG-1:0]  w_rs2_data;
  logic                w_rs1_busy;
  logic                w_rs2_busy;

  // Per-register request decode; out-of-range indices decode to no register.
  always_comb begin
    w_rsv_hit   = '0;
    w_wb_hit    = '0;
    w_tag_match = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rsv_hit[i]   = rsv_valid_i && (rsv_idx_i == LEN_IDX'(i));
      w_wb_hit[i]    = wb_valid_i  && (wb_idx_i  == LEN_IDX'(i));
      w_tag_match[i] = (wb_tag_i == r_tag[i]);
    end
  end

  // Register state; reservation is applied after write-back so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_data[i] <= INITIAL_DATA;
        r_tag[i]  <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wb_hit[i]) begin
          r_data[i] <= wb_data_i;
        end
        if (w_rsv_hit[i]) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= rsv_tag_i;
        end else if (w_wb_hit[i] && w_tag_match[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Read port 1; unmatched indices fall through to zero.
  always_comb begin
    w_rs1_data = '0;
    w_rs1_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs1_idx_i == LEN_IDX'(i)) begin
        w_rs1_data = r_data[i];
        w_rs1_busy = r_busy[i];
`ifdef REGISTER_FILE_SB_BYPASS_EN
        if (w_wb_hit[i]) begin
          w_rs1_data = wb_data_i;
          w_rs1_busy = w_rsv_hit[i] | (r_busy[i] & ~w_tag_match[i]);
        end
`endif
      end
    end
  end

  // Read port 2; same structure as port 1.
  always_comb begin
    w_rs2_data = '0;
    w_rs2_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs2_idx_i == LEN_IDX'(i)) begin
        w_rs2_data = r_data[i];
        w_rs2_busy = r_busy[i];
`ifdef REGISTER_FILE_SB_BYPASS_EN
        if (w_wb_hit[i]) begin
          w_rs2_data = wb_data_i;
          w_rs2_busy = w_rsv_hit[i] | (r_busy[i] & ~w_tag_match[i]);
        end
`endif
      end
    end
  end

  assign rs1_data_o = w_rs1_data;
  assign rs1_busy_o = w_rs1_busy;
  assign rs2_data_o = w_rs2_data;
  assign rs2_busy_o = w_rs2_busy;
  assign busy_vec_o = r_busy;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: scoreboard bench for register_file_sb (NUM_REGS=12,
// so indices 12..15 are out of range). Stimulus pushes expected read/busy
// values from a behavioural model into a queue; a monitor on the falling
// edge pops and compares. Honors REGISTER_FILE_SB_BYPASS_EN.
module tb_register_file_sb;

  localparam int unsigned LEN_REG  = 32;
  localparam int unsigned NUM_REGS = 12;
  localparam int unsigned LEN_IDX  = 4;
  localparam int unsigned LEN_TAG  = 3;
  localparam int unsigned SPAN     = 16;

  logic                clk;
  logic                rst;
  logic [LEN_IDX-1:0]  rs1_idx_i, rs2_idx_i;
  logic [LEN_REG-1:0]  rs1_data_o, rs2_data_o;
  logic                rs1_busy_o, rs2_busy_o;
  logic                rsv_valid_i;
  logic [LEN_IDX-1:0]  rsv_idx_i;
  logic [LEN_TAG-1:0]  rsv_tag_i;
  logic                wb_valid_i;
  logic [LEN_IDX-1:0]  wb_idx_i;
  logic [LEN_TAG-1:0]  wb_tag_i;
  logic [LEN_REG-1:0]  wb_data_i;
  logic [NUM_REGS-1:0] busy_vec_o;

  register_file_sb #(
    .LEN_REG (LEN_REG),
    .NUM_REGS(NUM_REGS),
    .LEN_IDX (LEN_IDX),
    .LEN_TAG (LEN_TAG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_idx_i  (rs1_idx_i),
    .rs2_idx_i  (rs2_idx_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .rs1_busy_o (rs1_busy_o),
    .rs2_busy_o (rs2_busy_o),
    .rsv_valid_i(rsv_valid_i),
    .rsv_idx_i  (rsv_idx_i),
    .rsv_tag_i  (rsv_tag_i),
    .wb_valid_i (wb_valid_i),
    .wb_idx_i   (wb_idx_i),
    .wb_tag_i   (wb_tag_i),
    .wb_data_i  (wb_data_i),
    .busy_vec_o (busy_vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]         d1;
    logic                b1;
    logic [31:0]         d2;
    logic                b2;
    logic [NUM_REGS-1:0] bv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: plain arrays indexed by register number.
  logic [31:0] m_data [SPAN];
  logic        m_busy [SPAN];
  logic [2:0]  m_tag  [SPAN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(SPAN); i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endfunction

  // Value seen on a read port this cycle, given the requests being presented.
  function automatic void model_read(input logic [3:0] idx, input logic rv, input logic [3:0] ri,
                                     input logic wv, input logic [3:0] wi, input logic [2:0] wt,
                                     input logic [31:0] wd, output logic [31:0] d, output logic b);
    int k = int'(idx);
    d = '0;
    b = 1'b0;
    if (k < int'(NUM_REGS)) begin
      d = m_data[k];
      b = m_busy[k];
`ifdef REGISTER_FILE_SB_BYPASS_EN
      if (wv && wi == idx) begin
        d = wd;
        if (rv && ri == idx) b = 1'b1;
        else if (m_tag[k] == wt) b = 1'b0;
      end
`else
      if (rv || wv || wt != 3'd0 || wd != 32'd0 || ri != 4'd0 || wi != 4'd0) begin
        d = m_data[k];
      end
`endif
    end
  endfunction

  // One clock of stimulus: drive, predict, let the edge happen, update model.
  task automatic cyc(input logic rst_v, input logic rv, input logic [3:0] ri, input logic [2:0] rt,
                     input logic wv, input logic [3:0] wi, input logic [2:0] wt, input logic [31:0] wd,
                     input logic [3:0] a1, input logic [3:0] a2);
    exp_t e;
    rst = rst_v; rsv_valid_i = rv; rsv_idx_i = ri; rsv_tag_i = rt;
    wb_valid_i = wv; wb_idx_i = wi; wb_tag_i = wt; wb_data_i = wd;
    rs1_idx_i = a1; rs2_idx_i = a2;
    if (!rst_v) model_reset();
    model_read(a1, rv, ri, wv, wi, wt, wd, e.d1, e.b1);
    model_read(a2, rv, ri, wv, wi, wt, wd, e.d2, e.b2);
    for (int i = 0; i < int'(NUM_REGS); i++) e.bv[i] = m_busy[i];
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_v) begin
      if (wv && int'(wi) < int'(NUM_REGS)) begin
        m_data[wi] = wd;
        if (m_tag[wi] == wt) m_busy[wi] = 1'b0;
      end
      if (rv && int'(ri) < int'(NUM_REGS)) begin
        m_busy[ri] = 1'b1;
        m_tag[ri]  = rt;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0, 32'd0, a1, a2);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rs1_data", rs1_data_o, e.d1);
      check("rs1_busy", 32'(rs1_busy_o), 32'(e.b1));
      check("rs2_data", rs2_data_o, e.d2);
      check("rs2_busy", 32'(rs2_busy_o), 32'(e.b2));
      check("busy_vec", 32'(busy_vec_o), 32'(e.bv));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; rsv_valid_i = 1'b0; rsv_idx_i = '0; rsv_tag_i = '0;
    wb_valid_i = 1'b0; wb_idx_i = '0; wb_tag_i = '0; wb_data_i = '0;
    rs1_idx_i = '0; rs2_idx_i = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state, first and last register.
    cyc(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0, 32'd0, 4'd0, 4'd11);
    idle(4'd0, 4'd11);
    // Reserve r3 tag 2, write back tag 2.
    cyc(1'b1, 1'b1, 4'd3, 3'd2, 1'b0, 4'd0, 3'd0, 32'd0, 4'd3, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 3'd2, 32'hDEADBEEF, 4'd3, 4'd3);
    idle(4'd3, 4'd0);
    // Stale tag on r5 keeps it busy; matching tag releases it.
    cyc(1'b1, 1'b1, 4'd5, 3'd1, 1'b0, 4'd0, 3'd0, 32'd0, 4'd5, 4'd0);
    cyc(1'b1, 1'b1, 4'd5, 3'd4, 1'b0, 4'd0, 3'd0, 32'd0, 4'd5, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd5, 3'd1, 32'h11, 4'd5, 4'd5);
    idle(4'd5, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd5, 3'd4, 32'h11, 4'd5, 4'd5);
    idle(4'd5, 4'd0);
    // Same-cycle reserve and write-back on r7: reservation wins.
    cyc(1'b1, 1'b1, 4'd7, 3'd6, 1'b1, 4'd7, 3'd6, 32'h55, 4'd7, 4'd7);
    idle(4'd7, 4'd0);
    // Independent reserve r8 and write-back r3 in one cycle.
    cyc(1'b1, 1'b1, 4'd8, 3'd5, 1'b1, 4'd3, 3'd0, 32'h1234, 4'd8, 4'd3);
    idle(4'd8, 4'd3);
    // Write-back r2 observed on rs2 (bypass-dependent).
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd2, 3'd0, 32'hA5A5, 4'd0, 4'd2);
    idle(4'd0, 4'd2);
    // Out-of-range index 14 is ignored and reads as zero.
    cyc(1'b1, 1'b1, 4'd14, 3'd3, 1'b1, 4'd14, 3'd3, 32'hFFFF, 4'd14, 4'd14);
    idle(4'd14, 4'd11);
    // Reset mid-operation drops reservations; later write-back leaves busy 0.
    cyc(1'b1, 1'b1, 4'd1, 3'd3, 1'b0, 4'd0, 3'd0, 32'd0, 4'd1, 4'd7);
    cyc(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0, 32'd0, 4'd1, 4'd7);
    idle(4'd1, 4'd7);
    cyc(1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd1, 3'd3, 32'hCAFE, 4'd1, 4'd1);
    idle(4'd1, 4'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic rs;
      rs = ($urandom_range(63, 0) != 0);
      cyc(rs, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 3'($urandom_range(3, 0)),
          1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 3'($urandom_range(3, 0)),
          $urandom(), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end

    // Drain: the scoreboard must be empty within a bounded number of cycles.
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
